divisor_sequencial: RTL and testbench
=====================================

// Module: divisor_sequencial
// PURPOSE
//  Sequential restoring shift-subtract divider: 2N-bit Dividendo / N-bit Divisor -> N-bit Quociente + N-bit Resto.
//  Inverse operation of the team's shift-add Multiplicador; same St/Idle/Done start-and-complete handshake.
//  Used wherever a product must be reduced back, e.g. scaling results from the multiplier datapath.
// PARAMETERS
//  N   4   operand width; Dividendo is 2N bits, Divisor/Quociente/Resto are N bits
// PORTS
//  Clk         in   1    single clock, all state updates on rising edge
//  Rst_n       in   1    synchronous reset, active-low
//  St          in   1    start request, sampled only in IDLE
//  Dividendo   in   2N   dividend, captured on the accepting edge
//  Divisor     in   N    divisor, captured on the accepting edge
//  Quociente   out  N    quotient, valid from Done until next accepted St
//  Resto       out  N    remainder, same validity as Quociente
//  V           out  1    overflow: quotient does not fit in N bits (includes divisor 0)
//  Idle        out  1    1 while in IDLE (ready to accept St)
//  Done        out  1    1 for exactly one cycle when result/overflow is final
//  Dz          out  1    divisor-zero flag (present only with DIV_ZERO_FLAG_EN)
// BEHAVIOUR
//  - Reset (Rst_n=0 at an edge): state=IDLE; Quociente=0, Resto=0, V=0, Done=0, Dz=0; Idle=1 after that edge.
//  - Reset wins over everything, including mid-operation; partial work is discarded, no Done issued.
//  - States: IDLE -> CHECK -> ITER (N cycles) -> DONE -> IDLE; overflow path CHECK -> DONE.
//  - IDLE: Idle=1. Edge with St=1: Acc(2N+1 bits)={1'b0,Dividendo}, Dvs=Divisor, V=0, go CHECK.
//    Quociente/Resto keep previous values until load; then they reflect internal registers (undefined until DONE).
//  - CHECK (1 cycle): if Acc[2N-1:N] >= Dvs (unsigned; Dvs=0 always true) -> V=1, go DONE.
//    Else counter=0, go ITER.
//  - ITER, one bit per cycle: T=Acc<<1; if T[2N:N] >= {1'b0,Dvs} then T[2N:N]-=Dvs, T[0]=1; Acc=T.
//    Compare/subtract in N+1 bits (no carry lost). After N-th iteration go DONE.
//  - DONE (1 cycle): Done=1, Idle=0. Quociente=Acc[N-1:0], Resto=Acc[2N-1:N]. Next edge -> IDLE.
//    On overflow: Quociente=0, Resto=0, V=1.
//  - Latency from accepting edge E0: normal Done high in cycle after edge E(N+1) (N+2 edges);
//    overflow Done high in cycle after E1. Idle high again after E(N+2) / E2.
//  - St=1 outside IDLE ignored; St held high continuously restarts on the edge after DONE->IDLE (back-to-back).
//  - Inputs may change after the accepting edge without affecting the operation.
//  - V and results held stable in IDLE until next accepted St (V cleared on that accept).
//  - All outputs registered or decoded from registered state only; no combinational path from inputs.
// CONFIGURATION
//  - DIV_ZERO_FLAG_EN defined: port Dz exists; in CHECK, Dvs==0 sets Dz=1 and V=1; Dz cleared on reset and on accept.
//  - DIV_ZERO_FLAG_EN undefined: no Dz port; divisor 0 reported only as V=1. Other behaviour identical.
// TESTING (N=4)
//  - Rst_n=0 one edge then 1, St=0 -> Idle=1, Done=0, V=0, Quociente=0, Resto=0.
//  - 8'd100 / 4'd7, St pulse -> Done after N+2=6 edges, Quociente=14, Resto=2, V=0; Done 1 cycle only.
//  - 8'd239 / 4'd15 -> Quociente=15, Resto=14, V=0; 8'd0 / 4'd3 -> Quociente=0, Resto=0.
//  - 8'd200 / 4'd5 -> Done 2 edges after accept, V=1, Quociente=0, Resto=0; next 8'd45/4'd11 -> 4 r 1, V=0.
//  - 8'd10 / 4'd0 -> V=1 (Dz=1 with DIV_ZERO_FLAG_EN); St held high whole cycle -> no re-accept before IDLE.
//  - Start 8'd100/4'd7, assert Rst_n=0 at 3rd edge -> IDLE, outputs 0, no Done; then 8'd36/4'd6 -> 6 r 0.
//  - Exhaustive sweep all 4096 dividend/divisor pairs vs reference model: q/r/V match, Done exactly once each.

Source files
------------

// File: rtl/divisor_sequencial.sv
// Sequential restoring shift-subtract divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional divide-by-zero flag port Dz is enabled by defining DIV_ZERO_FLAG_EN.
module divisor_sequencial #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           St,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic [N-1:0]   Quociente,
  output logic [N-1:0]   Resto,
  output logic           V,
  output logic           Idle,
  output logic           Done
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic           Dz
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ITER,
    DONE
  } state_t;

  state_t         state_reg;
  logic [2*N:0]   acc_reg;
  logic [2*N:0]   acc_next;
  logic [N-1:0]   dvs_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   quo_reg;
  logic [N-1:0]   res_reg;
  logic           v_reg;
  logic           done_reg;
  logic [N:0]     trial;
`ifdef DIV_ZERO_FLAG_EN
  logic           dz_reg;
`endif

  // One restoring step: shift left, then subtract the divisor from the
  // upper N+1 bits when it fits, shifting a quotient 1 into bit 0.
  always_comb begin
    acc_next = acc_reg << 1;
    trial    = acc_next[2*N:N];
    if (trial >= {1'b0, dvs_reg}) begin
      acc_next[2*N:N] = trial - {1'b0, dvs_reg};
      acc_next[0]     = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      res_reg   <= '0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (St) begin
            acc_reg   <= {1'b0, Dividendo};
            dvs_reg   <= Divisor;
            v_reg     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_reg    <= 1'b0;
`endif
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          // Upper half not below the divisor means the quotient needs more
          // than N bits; a zero divisor always lands here.
          if (acc_reg[2*N-1:N] >= dvs_reg) begin
            v_reg     <= 1'b1;
            quo_reg   <= '0;
            res_reg   <= '0;
            done_reg  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            dz_reg    <= (dvs_reg == '0);
`endif
            state_reg <= DONE;
          end else begin
            cnt_reg   <= '0;
            state_reg <= ITER;
          end
        end
        ITER: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(N - 1)) begin
            quo_reg   <= acc_next[N-1:0];
            res_reg   <= acc_next[2*N-1:N];
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Quociente = quo_reg;
  assign Resto     = res_reg;
  assign V         = v_reg;
  assign Done      = done_reg;
  assign Idle      = (state_reg == IDLE);
`ifdef DIV_ZERO_FLAG_EN
  assign Dz        = dz_reg;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
// Scoreboard bench for divisor_sequencial (N=4): stimulus pushes expected results, a monitor pops them on Done.
module tb_divisor_sequencial;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       St;
  logic [7:0] Dividendo;
  logic [3:0] Divisor;
  logic [3:0] Quociente;
  logic [3:0] Resto;
  logic       V;
  logic       Idle;
  logic       Done;
`ifdef DIV_ZERO_FLAG_EN
  logic       Dz;
`endif

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       v;
    logic       dz;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic done_prev = 1'b0;

  divisor_sequencial #(.N(4)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .V         (V),
    .Idle      (Idle),
    .Done      (Done)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .Dz        (Dz)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every Done must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && Done === 1'b1) begin
      if (done_prev) begin
        failures++;
        $display("FAIL done_width: Done high on consecutive cycles");
      end
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got q=%0d r=%0d v=%0d with no pending request", Quociente, Resto, V);
      end else begin
        exp_t e;
        logic bad;
        e   = sb_q.pop_front();
        bad = ({Quociente, Resto, V} !== {e.q, e.r, e.v});
`ifdef DIV_ZERO_FLAG_EN
        if (Dz !== e.dz) bad = 1'b1;
        if (bad) begin
          failures++;
          $display("FAIL result: got q=%0d r=%0d v=%0d dz=%0d, expected q=%0d r=%0d v=%0d dz=%0d",
                   Quociente, Resto, V, Dz, e.q, e.r, e.v, e.dz);
        end else
          $display("done q=%0d r=%0d v=%0d dz=%0d ok", Quociente, Resto, V, Dz);
`else
        if (bad) begin
          failures++;
          $display("FAIL result: got q=%0d r=%0d v=%0d, expected q=%0d r=%0d v=%0d",
                   Quociente, Resto, V, e.q, e.r, e.v);
        end
`endif
      end
    end
    done_prev = (Rst_n === 1'b1) && (Done === 1'b1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (Idle === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      failures++;
      checks++;
      $display("FAIL idle_timeout: Idle never returned");
    end
  endtask

  // Issue one division; hold keeps St high until Done is seen.
  task automatic run_op(input string name, input logic [7:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ev,
                        input logic edz, input int lat, input bit hold);
    int got = 0;
    wait_idle();
    sb_q.push_back('{q: eq, r: er, v: ev, dz: edz});
    Dividendo = a;
    Divisor   = b;
    St        = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        if (!hold) St = 1'b0;
        Dividendo = ~a;
        Divisor   = ~b;
      end
      if (Done === 1'b1) begin
        got = k;
        break;
      end
    end
    St = 1'b0;
    checks++;
    if (got != lat) begin
      failures++;
      $display("FAIL latency_%s: %0d/%0d got %0d cycles expected %0d", name, a, b, got, lat);
    end
  endtask

  initial begin
    int dones;
    int t_first;
    int t_second;
    St        = 1'b0;
    Dividendo = '0;
    Divisor   = '0;
    Rst_n     = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("rst_idle", {7'd0, Idle}, 8'd1);
    chk("rst_done", {7'd0, Done}, 8'd0);
    chk("rst_v", {7'd0, V}, 8'd0);
    chk("rst_q", {4'd0, Quociente}, 8'd0);
    chk("rst_r", {4'd0, Resto}, 8'd0);

    run_op("100_7", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 6, 1'b0);
    repeat (3) @(negedge Clk);
    chk("hold_q", {4'd0, Quociente}, 8'd14);
    chk("hold_r", {4'd0, Resto}, 8'd2);
    chk("hold_idle", {7'd0, Idle}, 8'd1);

    run_op("239_15", 8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 6, 1'b0);
    run_op("0_3", 8'd0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 6, 1'b0);
    run_op("200_5", 8'd200, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 2, 1'b0);
    chk("ovf_idle_after", {7'd0, Idle}, 8'd0);
    run_op("45_11", 8'd45, 4'd11, 4'd4, 4'd1, 1'b0, 1'b0, 6, 1'b0);
    run_op("10_0", 8'd10, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 2, 1'b1);
    repeat (4) @(negedge Clk);
    chk("no_reaccept", {7'd0, Idle}, 8'd1);

    // Back-to-back: St held high restarts one cycle after returning to IDLE.
    wait_idle();
    sb_q.push_back('{q: 4'd4, r: 4'd1, v: 1'b0, dz: 1'b0});
    sb_q.push_back('{q: 4'd4, r: 4'd1, v: 1'b0, dz: 1'b0});
    Dividendo = 8'd45;
    Divisor   = 4'd11;
    St        = 1'b1;
    dones = 0;
    t_first = 0;
    t_second = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        dones++;
        if (dones == 1) t_first = k;
        else begin
          t_second = k;
          St = 1'b0;
          break;
        end
      end
    end
    St = 1'b0;
    chk("b2b_dones", dones[7:0], 8'd2);
    chk("b2b_gap", 8'(t_second - t_first), 8'd7);

    // Reset in the middle of an operation discards it.
    wait_idle();
    Dividendo = 8'd100;
    Divisor   = 4'd7;
    St        = 1'b1;
    @(negedge Clk);
    St = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("midrst_idle", {7'd0, Idle}, 8'd1);
    chk("midrst_done", {7'd0, Done}, 8'd0);
    chk("midrst_q", {4'd0, Quociente}, 8'd0);
    chk("midrst_r", {4'd0, Resto}, 8'd0);
    chk("midrst_v", {7'd0, V}, 8'd0);
    repeat (10) @(negedge Clk);
    run_op("36_6", 8'd36, 4'd6, 4'd6, 4'd0, 1'b0, 1'b0, 6, 1'b0);

    // Exhaustive sweep against an arithmetic reference.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic       ov;
        logic [3:0] eq;
        logic [3:0] er;
        ov = ((a / 16) >= b);
        eq = ov ? 4'd0 : 4'(a / b);
        er = ov ? 4'd0 : 4'(a % b);
        run_op("sweep", 8'(a), 4'(b), eq, er, ov, (b == 0), ov ? 2 : 6, 1'b0);
      end
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
